// File: rtl/wb_copy_master.sv
// Wishbone Classic initiator that copies a block of words between bus addresses or fills a
// region with a constant, one single-beat cycle at a time.
module wb_copy_master #(
  parameter int unsigned WB_ADDR_WIDTH  = 24,
  parameter int unsigned WB_DATA_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       start_i,
  input  logic                       fill_i,
  input  logic [WB_ADDR_WIDTH-1:0]   src_adr_i,
  input  logic [WB_ADDR_WIDTH-1:0]   dst_adr_i,
  input  logic [LEN_WIDTH-1:0]       len_i,
  input  logic [WB_DATA_WIDTH-1:0]   fill_dat_i,
  input  logic                       abort_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [LEN_WIDTH-1:0]       count_o,
  output logic                       wbm_cyc_o,
  output logic                       wbm_stb_o,
  output logic                       wbm_we_o,
  output logic [WB_ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [WB_DATA_WIDTH-1:0]   wbm_dat_o,
  output logic [WB_DATA_WIDTH/8-1:0] wbm_sel_o,
  input  logic [WB_DATA_WIDTH-1:0]   wbm_dat_i,
  input  logic                       wbm_ack_i
);

  localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StGap, StFin} state_e;

  state_e                   state_q, state_d;
  logic                     fill_q, fill_d;
  logic [WB_ADDR_WIDTH-1:0] src_q, src_d;
  logic [WB_ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]     len_q, len_d;
  logic [WB_DATA_WIDTH-1:0] fill_dat_q, fill_dat_d;
  logic [WB_DATA_WIDTH-1:0] data_q, data_d;
  logic [LEN_WIDTH-1:0]     count_q, count_d;
  logic                     err_q, err_d;
  logic                     abort_q, abort_d;
  logic                     gap_wr_q, gap_wr_d;
  logic [TmoWidth-1:0]      tmo_q, tmo_d;

  logic                     busy, done, cyc, we;
  logic [WB_ADDR_WIDTH-1:0] adr;
  logic [WB_DATA_WIDTH-1:0] dat;
  logic [LEN_WIDTH-1:0]     count_inc;

  assign count_inc = count_q + LEN_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    fill_dat_d = fill_dat_q;
    data_d     = data_q;
    count_d    = count_q;
    err_d      = err_q;
    abort_d    = abort_q;
    gap_wr_d   = gap_wr_q;
    tmo_d      = '0;
    busy       = 1'b1;
    done       = 1'b0;
    cyc        = 1'b0;
    we         = 1'b0;
    adr        = '0;
    dat        = '0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start_i) begin
          fill_d     = fill_i;
          src_d      = src_adr_i;
          dst_d      = dst_adr_i;
          len_d      = len_i;
          fill_dat_d = fill_dat_i;
          err_d      = 1'b0;
          count_d    = '0;
          abort_d    = 1'b0;
          gap_wr_d   = fill_i;
          // An empty request still spends one busy cycle in GAP before FIN.
          if (len_i == '0) begin
            state_d = StGap;
          end else if (fill_i) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        abort_d = abort_q | abort_i;
        cyc     = 1'b1;
        adr     = src_q;
        if (wbm_ack_i) begin
          data_d   = wbm_dat_i;
          src_d    = src_q + WB_ADDR_WIDTH'(1);
          gap_wr_d = 1'b1;
          state_d  = StGap;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          tmo_d = tmo_q + TmoWidth'(1);
        end
      end
      StWr: begin
        abort_d = abort_q | abort_i;
        cyc     = 1'b1;
        we      = 1'b1;
        adr     = dst_q;
        dat     = fill_q ? fill_dat_q : data_q;
        if (wbm_ack_i) begin
          dst_d    = dst_q + WB_ADDR_WIDTH'(1);
          count_d  = count_inc;
          gap_wr_d = fill_q;
          if ((count_inc == len_q) || abort_q || abort_i) begin
            state_d = StFin;
          end else begin
            state_d = StGap;
          end
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          tmo_d = tmo_q + TmoWidth'(1);
        end
      end
      StGap: begin
        abort_d = abort_q | abort_i;
        if (count_q == len_q) begin
          state_d = StFin;
        end else if (gap_wr_q) begin
          state_d = StWr;
        end else begin
          state_d = StRd;
        end
      end
      StFin: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      fill_q     <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      fill_dat_q <= '0;
      data_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      gap_wr_q   <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      fill_dat_q <= fill_dat_d;
      data_q     <= data_d;
      count_q    <= count_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
      gap_wr_q   <= gap_wr_d;
      tmo_q      <= tmo_d;
    end
  end

  assign busy_o    = busy;
  assign done_o    = done;
  assign err_o     = err_q;
  assign count_o   = count_q;
  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = cyc;
  assign wbm_we_o  = we;
  assign wbm_adr_o = adr;
  assign wbm_dat_o = dat;
  assign wbm_sel_o = '1;

endmodule

// File: tb/tb_wb_copy_master.sv
// Self-checking bench for wb_copy_master: table of directed operations, randomized operations
// against a transfer-list reference model, and hand-written reset/abort sequences.
module tb_wb_copy_master;

  localparam int Tmo = 16;

  logic        clk = 1'b0;
  logic        rst, start, fill, abort;
  logic [23:0] src, dst;
  logic [15:0] len, fdat;
  logic        busy, done, err;
  logic [15:0] count;
  logic        cyc, stb, we;
  logic [23:0] adr;
  logic [15:0] dat_o, dat_i;
  logic [1:0]  sel;
  logic        ack;

  wb_copy_master #(
    .WB_ADDR_WIDTH (24),
    .WB_DATA_WIDTH (16),
    .LEN_WIDTH     (16),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .start_i   (start),
    .fill_i    (fill),
    .src_adr_i (src),
    .dst_adr_i (dst),
    .len_i     (len),
    .fill_dat_i(fdat),
    .abort_i   (abort),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err),
    .count_o   (count),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we),
    .wbm_adr_o (adr),
    .wbm_dat_o (dat_o),
    .wbm_sel_o (sel),
    .wbm_dat_i (dat_i),
    .wbm_ack_i (ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [23:0] adr;
    logic [15:0] dat;
  } xfer_t;

  typedef struct {
    bit          fill;
    logic [23:0] src;
    logic [23:0] dst;
    logic [15:0] len;
    logic [15:0] fd;
    int          lat;
    int          abort_rd;   // -1 none, 0 with start, k>0 during k-th read
    bit          stall_en;
    logic [23:0] stall_adr;
    bit          idle_abort;
    bit          poke;
    int          exp_count;
    bit          exp_err;
  } vec_t;

  int          n_checks = 0;
  int          n_err = 0;
  int          lat = 1;
  bit          stall_en = 1'b0;
  logic [23:0] stall_adr = '0;
  logic [15:0] seed = '0;
  int          wcnt;
  xfer_t       exp_q[$];

  function automatic logic [15:0] rd_val(input logic [23:0] a);
    if (a >= 24'h100 && a <= 24'h103) return 16'h1111 * 16'(a - 24'h0ff);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ seed;
  endfunction

  // Slave: acks lat cycles after stb rises; never acks a read of stall_adr when stalling.
  always @(posedge clk) begin
    if (rst) begin
      ack   <= 1'b0;
      wcnt  <= 0;
      dat_i <= '0;
    end else if (cyc && stb && !ack) begin
      wcnt <= wcnt + 1;
      if (wcnt == lat - 1 && !(stall_en && !we && adr == stall_adr)) begin
        ack   <= 1'b1;
        dat_i <= we ? 16'h0 : rd_val(adr);
      end
    end else begin
      ack  <= 1'b0;
      wcnt <= 0;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(bit f, logic [23:0] s, logic [23:0] d, logic [15:0] l,
                              logic [15:0] fd, int lt, int ab, bit st, logic [23:0] sa,
                              bit ia, bit pk, int ec, bit ee);
    vec_t v;
    v.fill = f; v.src = s; v.dst = d; v.len = l; v.fd = fd; v.lat = lt; v.abort_rd = ab;
    v.stall_en = st; v.stall_adr = sa; v.idle_abort = ia; v.poke = pk;
    v.exp_count = ec; v.exp_err = ee;
    return v;
  endfunction

  // Reference: expected transfer list, words written, error flag and done cycle.
  task automatic model(input vec_t v, output int words, output bit merr, output int done_c);
    exp_q.delete();
    words = 0;
    merr  = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      logic [23:0] sa, da;
      logic [15:0] d;
      sa = v.src + 24'(i);
      da = v.dst + 24'(i);
      if (!v.fill && v.stall_en && sa == v.stall_adr) begin
        merr = 1'b1;
        break;
      end
      d = v.fill ? v.fd : rd_val(sa);
      if (!v.fill) exp_q.push_back({1'b0, sa, d});
      exp_q.push_back({1'b1, da, d});
      words = i + 1;
      if (!v.fill && v.abort_rd > 0 && words == v.abort_rd) break;
    end
    if (merr) done_c = 2 * words * (v.lat + 2) + 1 + Tmo;
    else if (v.len == 0) done_c = 2;
    else done_c = exp_q.size() * (v.lat + 2);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_cyc_stb_we"}, {cyc, stb, we}, 0);
    check({tag, "_adr"}, adr, 0);
    check({tag, "_dat"}, dat_o, 0);
    check({tag, "_sel"}, sel, 2'b11);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int    words, done_exp, first_done, n_done, rd_seen, run, max_run;
    bit    merr, gap_ok, bus_ok, prev_ack, prev_stb, abort_hold;
    xfer_t got_q[$];
    model(v, words, merr, done_exp);
    lat = v.lat;
    stall_en = v.stall_en;
    stall_adr = v.stall_adr;
    if (v.idle_abort) begin
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b1; fill = v.fill; src = v.src; dst = v.dst; len = v.len; fdat = v.fd;
    abort = (v.abort_rd == 0);
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    first_done = -1; n_done = 0; rd_seen = 0; run = 0; max_run = 0;
    gap_ok = 1'b1; bus_ok = 1'b1; prev_ack = 1'b0; prev_stb = 1'b0; abort_hold = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (abort_hold) begin
        abort = 1'b0;
        abort_hold = 1'b0;
      end
      if (c == 1) begin
        check({tag, "_busy_start"}, busy, 1);
        check({tag, "_err_cleared"}, err, 0);
        check({tag, "_count_cleared"}, count, 0);
      end
      if (v.poke && c == 3) begin
        start = 1'b1; fill = !v.fill; len = v.len + 16'd5; src = ~v.src; dst = ~v.dst;
      end
      if (v.poke && c == 4) start = 1'b0;
      if (stb && !prev_stb) begin
        run = 0;
        if (!we) begin
          rd_seen++;
          if (v.abort_rd > 0 && rd_seen == v.abort_rd) begin
            abort = 1'b1;
            abort_hold = 1'b1;
          end
        end
      end
      if (stb) run++;
      if (!stb && prev_stb && run > max_run) max_run = run;
      if (stb && sel != 2'b11) bus_ok = 1'b0;
      if (cyc != stb) bus_ok = 1'b0;
      if (done && busy) bus_ok = 1'b0;
      if (stb && prev_ack) gap_ok = 1'b0;
      if (stb && ack) got_q.push_back({we, adr, we ? dat_o : dat_i});
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      prev_ack = stb && ack;
      prev_stb = stb;
      if (first_done >= 0 && c >= first_done + 2) break;
    end
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_done_cycle"}, first_done, done_exp);
    check({tag, "_count"}, count, words);
    check({tag, "_err"}, err, merr);
    check({tag, "_idle_after"}, {busy, cyc}, 0);
    check({tag, "_gap"}, gap_ok, 1);
    check({tag, "_bus"}, bus_ok, 1);
    if (merr) check({tag, "_tmo_len"}, max_run, Tmo);
    check({tag, "_nxfers"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_xfer%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  vec_t tv[10];
  vec_t rv;
  bit   ok;

  initial begin
    rst = 1'b1; start = 1'b0; fill = 1'b0; abort = 1'b0;
    src = '0; dst = '0; len = '0; fdat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    tv[0] = mk(0, 24'h000100, 24'h000200, 4, 16'h0, 3, -1, 0, 0, 0, 0, 4, 0);
    tv[1] = mk(1, 24'h0, 24'h000010, 3, 16'ha5a5, 2, -1, 0, 0, 0, 0, 3, 0);
    tv[2] = mk(0, 24'h000100, 24'h000200, 0, 16'h0, 2, -1, 0, 0, 0, 0, 0, 0);
    tv[3] = mk(0, 24'h000100, 24'h000300, 4, 16'h0, 2, -1, 1, 24'h000101, 0, 0, 1, 1);
    tv[4] = mk(1, 24'h0, 24'hfffffe, 4, 16'h1234, 1, -1, 0, 0, 0, 0, 4, 0);
    tv[5] = mk(0, 24'h000100, 24'h000400, 8, 16'h0, 2, 2, 0, 0, 0, 0, 2, 0);
    tv[6] = mk(0, 24'h000500, 24'h000600, 5, 16'h0, 1, -1, 0, 0, 0, 1, 5, 0);
    tv[7] = mk(0, 24'h000700, 24'h000800, 3, 16'h0, 1, -1, 0, 0, 1, 0, 3, 0);
    tv[8] = mk(0, 24'h000900, 24'h000a00, 3, 16'h0, 2, 0, 0, 0, 0, 0, 3, 0);
    tv[9] = mk(0, 24'hffffff, 24'h000020, 3, 16'h0, 1, -1, 0, 0, 0, 0, 3, 0);

    for (int i = 0; i < 10; i++) begin
      seed = 16'($urandom);
      run_op(tv[i], $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tbl_count", i), count, tv[i].exp_count);
      check($sformatf("vec%0d_tbl_err", i), err, tv[i].exp_err);
    end

    for (int i = 0; i < 24; i++) begin
      seed = 16'($urandom);
      rv.fill = 1'($urandom_range(0, 1));
      rv.src = 24'($urandom);
      rv.dst = 24'($urandom);
      rv.len = 16'($urandom_range(0, 10));
      rv.fd = 16'($urandom);
      rv.lat = $urandom_range(1, 4);
      rv.abort_rd = (rv.len > 0 && $urandom_range(0, 3) == 0) ?
                    int'($urandom_range(1, int'(rv.len))) : -1;
      rv.stall_en = !rv.fill && rv.len > 0 && $urandom_range(0, 4) == 0;
      rv.stall_adr = rv.len > 0 ? rv.src + 24'($urandom_range(0, int'(rv.len) - 1)) : '0;
      rv.idle_abort = $urandom_range(0, 3) == 0;
      rv.poke = rv.len >= 2 && $urandom_range(0, 1) == 1;
      run_op(rv, $sformatf("rnd%0d", i));
    end

    // Reset during the third write of a fill: bus released at once, nothing afterwards.
    stall_en = 1'b0;
    lat = 4;
    @(posedge clk); #1;
    start = 1'b1; fill = 1'b1; dst = 24'h000040; len = 16'd8; fdat = 16'h5a5a;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (stb && we && count == 16'd2) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_mid_reached", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (stb || cyc || busy) ok = 1'b0;
    end
    check("rst_mid_quiet", ok, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_copy_master.md
Name: wb_copy_master

Overview:
- Wishbone Classic initiator (master) that moves blocks of words between bus addresses, or fills a region with a constant.
- Drives the memory controller's slave port, e.g. for frame-buffer clears and ROM-to-RAM shadowing during boot.
- Issues one single-beat Classic cycle at a time: read source, then write destination.

Parameters:
- WB_ADDR_WIDTH, 24, word address width on the bus.
- WB_DATA_WIDTH, 16, data width; byte selects are WB_DATA_WIDTH/8 bits wide.
- LEN_WIDTH, 16, width of the word-count field.
- TIMEOUT_CYCLES, 1024, maximum cycles waiting for ack before the operation is aborted with error.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle request; sampled only in IDLE.
- fill_i  in  1  1 = fill mode (no reads), 0 = copy mode; latched on start.
- src_adr_i  in  WB_ADDR_WIDTH  source word address; latched on start.
- dst_adr_i  in  WB_ADDR_WIDTH  destination word address; latched on start.
- len_i  in  LEN_WIDTH  number of words; latched on start.
- fill_dat_i  in  WB_DATA_WIDTH  fill value; latched on start.
- abort_i  in  1  stop at the next word boundary.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle pulse at the end of the operation (normal, abort or error).
- err_o  out  1  sticky timeout flag; cleared by the next accepted start.
- count_o  out  LEN_WIDTH  words fully written so far.
- wbm_cyc_o  out  1  cycle valid.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_adr_o  out  WB_ADDR_WIDTH  address.
- wbm_dat_o  out  WB_DATA_WIDTH  write data.
- wbm_sel_o  out  WB_DATA_WIDTH/8  byte selects; all ones whenever stb is asserted.
- wbm_dat_i  in  WB_DATA_WIDTH  read data.
- wbm_ack_i  in  1  acknowledge.

Behaviour:
- Reset (synchronous) values:
  - All outputs are 0, except wbm_sel_o, which is all ones.
  - State is IDLE.
  - Any bus cycle in progress is dropped in the cycle after reset is sampled.
- States: IDLE, RD, WR, GAP, FIN.
- IDLE:
  - start_i=1 latches all inputs, sets busy_o=1, clears err_o and count_o.
  - len=0 goes to FIN.
  - fill goes to WR; copy goes to RD.
- RD:
  - Outputs: cyc=stb=1, we=0, adr=src pointer.
  - Signals are held stable until ack.
  - On ack: capture wbm_dat_i into the data register, increment src (wrap modulo 2^WB_ADDR_WIDTH), go to WR via GAP.
- WR:
  - Outputs: cyc=stb=1, we=1, adr=dst pointer, dat=data register (fill mode: fill value).
  - On ack: increment dst (wrap), count_o+1.
  - If count reaches len or abort is pending, go to FIN; otherwise go to GAP then RD (copy) or WR (fill).
- GAP:
  - Exactly one cycle with cyc=stb=0.
  - Every Classic cycle is followed by at least one idle cycle, so a slave never sees stb still high after its ack.
- FIN:
  - Outputs: done_o=1 for one cycle, busy_o=0, return to IDLE.
- Ack handling:
  - cyc/stb are registered and deasserted in the cycle after ack is sampled.
  - Ack while stb=0 is ignored.
- Timeout:
  - A counter resets at each stb rising.
  - If TIMEOUT_CYCLES elapse in RD/WR without ack: drop cyc/stb, set err_o=1, go to FIN.
  - count_o then reflects completed writes only.
- abort_i:
  - Latched into a pending flag while busy.
  - Honoured only after the current write ack; a pending read completes and its write is also performed.
  - Abort in IDLE is ignored.
- start_i while busy is ignored.
- start and abort in the same cycle in IDLE: start is accepted and abort is ignored.
- Latency:
  - Copy: each word costs read ack + 1 gap cycle + write ack + 1 gap cycle.
  - done_o asserts 1 cycle after the final write ack.
  - For len=0: busy_o is high 1 cycle and done_o pulses in the 2nd cycle after start.

Test Plan:
- Copy mode, src=0x000100, dst=0x000200, len=4; slave model acks 3 cycles after stb, mem[0x100..0x103]=0x1111..0x4444 -> mem[0x200..0x203] match, count_o=4, one done_o, err_o=0, cyc low ≥1 cycle between all 8 transfers.
- Fill mode, dst=0x000010, len=3, fill=0xA5A5 -> exactly 3 write cycles, zero reads, addresses 0x10..0x12, sel=2'b11.
- len=0 -> no cyc assertion; done_o pulses 2 cycles after start.
- Slave never acks on the 2nd read, TIMEOUT_CYCLES=16 -> cyc drops 16 cycles after stb, err_o=1, count_o=1, done_o pulse; next start clears err_o.
- Wrap: dst=0xFFFFFE, len=4, fill -> write addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- abort_i pulsed during the 2nd read of len=8 -> 2nd write still completes, count_o=2, done_o; wb_rst_i asserted mid-write in another run -> all outputs return to reset values the next cycle, no further stb.
